// File: rtl/frame_sequencer_pkg.sv
// Shared image-pipeline definitions: sequencer state encoding and the
// counter-width helper used to size col/row/flush counters.
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2,
    StDone  = 2'd3
  } seq_state_e;

  // Width needed to hold 0..n-1; never below one bit so degenerate sizes stay legal.
  function automatic int unsigned clog2w(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : $clog2(n);
  endfunction

endpackage

// File: rtl/frame_sequencer_counter.sv
// frame_counter: column/row position of the current pixel within a frame.
// Ports:
//   clock  - rising-edge clock
//   reset  - synchronous active-low reset
//   clear  - synchronous clear of col/row
//   inc    - advance by one pixel (col wraps at IMG_WIDTH-1 and bumps row)
//   col    - current column
//   row    - current row
//   last   - position is the final pixel of the frame
module frame_counter
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 720,
  parameter int unsigned IMG_HEIGHT = 540
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          inc,
  output logic [clog2w(IMG_WIDTH)-1:0]  col,
  output logic [clog2w(IMG_HEIGHT)-1:0] row,
  output logic                          last
);

  localparam int unsigned ColW = clog2w(IMG_WIDTH);
  localparam int unsigned RowW = clog2w(IMG_HEIGHT);
  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  logic [ColW-1:0] col_q;
  logic [RowW-1:0] row_q;
  logic            col_wrap;
  logic            row_wrap;

  assign col_wrap = (col_q == ColLast);
  assign row_wrap = (row_q == RowLast);
  assign last     = col_wrap && row_wrap;
  assign col      = col_q;
  assign row      = row_q;

  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (inc) begin
      if (col_wrap) begin
        col_q <= '0;
        row_q <= row_wrap ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: moves one frame of pixels from a first-word-fall-through
// source FIFO into the pipeline input FIFO, then appends FLUSH_PIXELS zero
// pixels to drain the window stages.
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-low reset
//   start, abort          - frame request / immediate termination
//   in_dout, in_empty     - source FIFO data and empty flag
//   in_rd_en              - source FIFO pop
//   out_din, out_wr_en    - pipeline FIFO data and push
//   out_full              - pipeline FIFO full
//   col, row              - position of the pixel being pushed
//   sof, eol              - first pixel of frame / last pixel of row (with push)
//   busy, frame_done      - not idle / one-cycle completion pulse
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned IMG_WIDTH    = 720,
  parameter int unsigned IMG_HEIGHT   = 540,
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned FLUSH_PIXELS = 2 * IMG_WIDTH + 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [DWIDTH-1:0]             in_dout,
  input  logic                          in_empty,
  output logic                          in_rd_en,
  output logic [DWIDTH-1:0]             out_din,
  input  logic                          out_full,
  output logic                          out_wr_en,
  output logic [clog2w(IMG_WIDTH)-1:0]  col,
  output logic [clog2w(IMG_HEIGHT)-1:0] row,
  output logic                          sof,
  output logic                          eol,
  output logic                          busy,
  output logic                          frame_done
);

  localparam int unsigned ColW   = clog2w(IMG_WIDTH);
  localparam int unsigned FlushW = clog2w(FLUSH_PIXELS);
  localparam logic [ColW-1:0]   ColLast   = ColW'(IMG_WIDTH - 1);
  localparam logic [FlushW-1:0] FlushLast = FlushW'((FLUSH_PIXELS == 0) ? 0 : FLUSH_PIXELS - 1);
  localparam bit HasFlush = (FLUSH_PIXELS != 0);

  seq_state_e        state_q;
  logic [FlushW-1:0] flush_cnt_q;
  logic              active;
  logic              run_xfer;
  logic              flush_push;
  logic              last;

  // Reset and abort both suppress any transfer in the cycle they are seen.
  assign active     = reset && !abort;
  assign run_xfer   = active && (state_q == StRun) && !in_empty && !out_full;
  assign flush_push = active && (state_q == StFlush) && !out_full;

  assign in_rd_en   = run_xfer;
  assign out_wr_en  = run_xfer || flush_push;
  assign out_din    = run_xfer ? in_dout : '0;
  assign sof        = run_xfer && (col == '0) && (row == '0);
  assign eol        = run_xfer && (col == ColLast);
  assign busy       = (state_q != StIdle);
  assign frame_done = active && (state_q == StDone);

  // Held clear while idle so every frame starts at (0,0).
  frame_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_frame_counter (
    .clock (clock),
    .reset (reset),
    .clear (abort || (state_q == StIdle)),
    .inc   (run_xfer),
    .col   (col),
    .row   (row),
    .last  (last)
  );

  always_ff @(posedge clock) begin
    if (!reset || abort) begin
      state_q     <= StIdle;
      flush_cnt_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StRun;
        end
        StRun: begin
          if (run_xfer && last) state_q <= HasFlush ? StFlush : StDone;
        end
        StFlush: begin
          if (flush_push) begin
            if (flush_cnt_q == FlushLast) begin
              flush_cnt_q <= '0;
              state_q     <= StDone;
            end else begin
              flush_cnt_q <= flush_cnt_q + 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 2;
  localparam int unsigned F  = 3;
  localparam int unsigned DW = 8;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start0 = 1'b0;
  logic abort = 1'b0;
  logic out_full = 1'b0;
  logic stall_empty = 1'b0;

  always #5 clock = ~clock;

  // Source FIFO model (first-word-fall-through), only the monitor advances src_rd.
  logic [DW-1:0] src_mem [0:127];
  int            src_rd  = 0;
  int            src_cnt = 0;
  int            src0_rd = 0;

  logic [DW-1:0] in_dout, out_din, in_dout0, out_din0;
  logic          in_empty, in_rd_en, out_wr_en, sof, eol, busy, frame_done;
  logic          in_rd_en0, out_wr_en0, sof0, eol0, busy0, frame_done0;
  logic [1:0]    col, col0;
  logic [0:0]    row, row0;

  assign in_empty = (src_rd >= src_cnt) || stall_empty;
  assign in_dout  = (src_rd < src_cnt) ? src_mem[src_rd[6:0]] : '0;
  assign in_dout0 = DW'(src0_rd + 1);

  frame_sequencer #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DWIDTH       (DW),
    .FLUSH_PIXELS (F)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .in_dout    (in_dout),
    .in_empty   (in_empty),
    .in_rd_en   (in_rd_en),
    .out_din    (out_din),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en),
    .col        (col),
    .row        (row),
    .sof        (sof),
    .eol        (eol),
    .busy       (busy),
    .frame_done (frame_done)
  );

  frame_sequencer #(
    .IMG_WIDTH    (W),
    .IMG_HEIGHT   (H),
    .DWIDTH       (DW),
    .FLUSH_PIXELS (0)
  ) dut0 (
    .clock      (clock),
    .reset      (reset),
    .start      (start0),
    .abort      (abort),
    .in_dout    (in_dout0),
    .in_empty   (1'b0),
    .in_rd_en   (in_rd_en0),
    .out_din    (out_din0),
    .out_full   (out_full),
    .out_wr_en  (out_wr_en0),
    .col        (col0),
    .row        (row0),
    .sof        (sof0),
    .eol        (eol0),
    .busy       (busy0),
    .frame_done (frame_done0)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          sof;
    logic          eol;
  } exp_t;

  exp_t exp_q[$];
  int   push_cyc[$];
  int   compared = 0;
  int   mismatched = 0;
  int   cyc = 0;
  int   push_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = -1;
  int   push0_cnt = 0;
  int   last_push0_cyc = -1;
  int   done0_cnt = 0;
  int   done0_cyc = -1;
  logic [DW-1:0] last0_data = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on every push.
  always @(posedge clock) begin
    exp_t e;
    if (out_wr_en) begin
      push_cnt++;
      push_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_push", 32'(out_din), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("push_data", 32'(out_din), 32'(e.data));
        check("push_sof", 32'(sof), 32'(e.sof));
        check("push_eol", 32'(eol), 32'(e.eol));
      end
    end
    if (in_rd_en) begin
      if (!out_wr_en) check("pop_without_push", 32'(out_wr_en), 32'd1);
      src_rd <= src_rd + 1;
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_wr_en0) begin
      push0_cnt++;
      last0_data = out_din0;
      last_push0_cyc = cyc;
    end
    if (in_rd_en0) src0_rd <= src0_rd + 1;
    if (frame_done0) begin
      done0_cnt++;
      done0_cyc = cyc;
    end
    cyc++;
  end

  task automatic load_src(input int n);
    for (int i = 0; i < n; i++) src_mem[(src_rd + i) % 128] = DW'(i + 1);
    src_cnt = src_rd + n;
  endtask

  task automatic expect_data(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.data = DW'(i + 1);
      e.sof  = (i == 0);
      e.eol  = ((i % W) == W - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_flush(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back('{data: '0, sof: 1'b0, eol: 1'b0});
  endtask

  task automatic new_test();
    push_cnt = 0;
    push_cyc.delete();
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    int n = 0;
    while (done_cnt < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_done_seen"}, 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic wait_pushes(input string tag, input int target);
    int n = 0;
    while (push_cnt < target && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({tag, "_pushes_seen"}, 32'(push_cnt >= target), 32'd1);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
    check({tag, "_in_rd_en"}, 32'(in_rd_en), 32'd0);
    check({tag, "_out_wr_en"}, 32'(out_wr_en), 32'd0);
    check({tag, "_sof"}, 32'(sof), 32'd0);
    check({tag, "_eol"}, 32'(eol), 32'd0);
    check({tag, "_out_din"}, 32'(out_din), 32'd0);
    check({tag, "_col"}, 32'(col), 32'd0);
    check({tag, "_row"}, 32'(row), 32'd0);
  endtask

  initial begin
    int base_done;
    int m_col;
    int m_row;
    int n;
    int k;

    // Reset state, with data already waiting at the source.
    load_src(8);
    repeat (3) @(negedge clock);
    check_idle_outputs("reset");
    reset = 1'b1;
    @(negedge clock);
    check("idle_no_push", 32'(out_wr_en), 32'd0);
    src_cnt = src_rd;

    // Full frame, no back-pressure.
    new_test();
    load_src(8);
    expect_data(8);
    expect_flush(F);
    pulse_start();
    check("t1_busy", 32'(busy), 32'd1);
    wait_done("t1", 1);
    check("t1_push_count", 32'(push_cnt), 32'd11);
    check("t1_data_span", 32'((push_cyc.size() >= 8) ? push_cyc[7] - push_cyc[0] : -1), 32'd7);
    check("t1_done_latency", 32'(done_cyc),
          32'((push_cyc.size() >= 11) ? push_cyc[10] + 1 : -1));
    @(negedge clock);
    check("t1_done_one_cycle", 32'(done_cnt), 32'd1);
    check("t1_idle", 32'(busy), 32'd0);

    // Back-pressure on RUN cycles 3..5.
    new_test();
    load_src(8);
    expect_data(8);
    expect_flush(F);
    pulse_start();
    @(negedge clock);
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      if (j == 0) check("t2_pushes_before_full", 32'(push_cnt), 32'd2);
      out_full = 1'b1;
      #1;
      check("t2_full_no_push", 32'(out_wr_en), 32'd0);
      check("t2_full_no_pop", 32'(in_rd_en), 32'd0);
    end
    @(negedge clock);
    out_full = 1'b0;
    wait_done("t2", 2);
    check("t2_push_count", 32'(push_cnt), 32'd11);

    // Source empty every other cycle.
    new_test();
    load_src(8);
    expect_data(8);
    expect_flush(F);
    pulse_start();
    m_col = 0;
    m_row = 0;
    n = 0;
    k = 0;
    while (n < 8 && k < 60) begin
      stall_empty = (k % 2 == 1);
      #1;
      check("t3_col", 32'(col), 32'(m_col));
      check("t3_row", 32'(row), 32'(m_row));
      check("t3_push_when_ready", 32'(out_wr_en), 32'(k % 2 == 0));
      if (k % 2 == 0) begin
        n++;
        if (m_col == W - 1) begin
          m_col = 0;
          m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
      @(negedge clock);
      k++;
    end
    stall_empty = 1'b0;
    wait_done("t3", 3);
    check("t3_push_count", 32'(push_cnt), 32'd11);

    // Abort at the 5th transfer.
    new_test();
    load_src(8);
    expect_data(4);
    base_done = done_cnt;
    pulse_start();
    wait_pushes("t4", 4);
    check("t4_col_at_abort", 32'(col), 32'd0);
    check("t4_row_at_abort", 32'(row), 32'd1);
    abort = 1'b1;
    #1;
    check("t4_abort_no_push", 32'(out_wr_en), 32'd0);
    check("t4_abort_no_pop", 32'(in_rd_en), 32'd0);
    @(negedge clock);
    abort = 1'b0;
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_col", 32'(col), 32'd0);
    check("t4_row", 32'(row), 32'd0);
    repeat (3) @(negedge clock);
    check("t4_push_count", 32'(push_cnt), 32'd4);
    check("t4_no_done", 32'(done_cnt), 32'(base_done));
    src_cnt = src_rd;

    // Start held through RUN, then start+abort in IDLE.
    new_test();
    load_src(8);
    expect_data(8);
    expect_flush(F);
    base_done = done_cnt;
    @(negedge clock);
    start = 1'b1;
    wait_pushes("t5", 8);
    start = 1'b0;
    check("t5_busy_in_flush", 32'(busy), 32'd1);
    wait_done("t5", base_done + 1);
    @(negedge clock);
    check("t5_push_count", 32'(push_cnt), 32'd11);
    check("t5_single_done", 32'(done_cnt), 32'(base_done + 1));
    load_src(1);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    start = 1'b0;
    abort = 1'b0;
    check("t5_start_abort_idle", 32'(busy), 32'd0);
    repeat (2) @(negedge clock);
    check("t5_no_restart_push", 32'(push_cnt), 32'd11);
    src_cnt = src_rd;

    // FLUSH_PIXELS = 0: DONE directly after the last data pixel.
    @(negedge clock);
    start0 = 1'b1;
    @(negedge clock);
    start0 = 1'b0;
    n = 0;
    while (done0_cnt < 1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("t6_done_seen", 32'(done0_cnt), 32'd1);
    check("t6_push_count", 32'(push0_cnt), 32'd8);
    check("t6_last_data", 32'(last0_data), 32'd8);
    check("t6_done_latency", 32'(done0_cyc), 32'(last_push0_cyc + 1));

    // Reset in the middle of FLUSH.
    new_test();
    load_src(8);
    expect_data(8);
    expect_flush(1);
    base_done = done_cnt;
    pulse_start();
    wait_pushes("t7", 9);
    reset = 1'b0;
    #1;
    check("t7_reset_no_push", 32'(out_wr_en), 32'd0);
    @(negedge clock);
    check_idle_outputs("t7");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("t7_push_count", 32'(push_cnt), 32'd9);
    check("t7_no_done", 32'(done_cnt), 32'(base_done));
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
